// File: rtl/priority_4bit_encoder.sv
// Registered 4-request priority encoder (index, valid, multi; optional one-hot grant via PRIO_ONEHOT_EN).
// Latency: 1 clk from sampling a/en to outputs; no combinational path from inputs to outputs.
// Backpressure: none; en=0 holds every output register.
module priority_4bit_encoder #(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] a,
  output logic [1:0] b,
  output logic       valid,
`ifdef PRIO_ONEHOT_EN
  output logic [3:0] grant,
`endif
  output logic       multi
);

  logic [1:0] win_idx;
  logic       any_req;
  logic       many_req;

  always_comb begin
    win_idx = 2'd0;
    if (HIGH_FIRST) begin
      if (a[3])      win_idx = 2'd3;
      else if (a[2]) win_idx = 2'd2;
      else if (a[1]) win_idx = 2'd1;
      else           win_idx = 2'd0;
    end else begin
      if (a[0])      win_idx = 2'd0;
      else if (a[1]) win_idx = 2'd1;
      else if (a[2]) win_idx = 2'd2;
      else if (a[3]) win_idx = 2'd3;
      else           win_idx = 2'd0;
    end
  end

  assign any_req  = |a;
  // Clearing the lowest set bit leaves something only when two or more bits were set.
  assign many_req = (a & (a - 4'd1)) != 4'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b     <= 2'd0;
      valid <= 1'b0;
      multi <= 1'b0;
    end else if (en) begin
      b     <= win_idx;
      valid <= any_req;
      multi <= many_req;
    end
  end

`ifdef PRIO_ONEHOT_EN
  logic [3:0] win_oh;

  assign win_oh = any_req ? (4'b0001 << win_idx) : 4'b0000;

  always_ff @(posedge clk) begin
    if (!rst_n)  grant <= 4'b0000;
    else if (en) grant <= win_oh;
  end
`endif

endmodule

// File: tb/tb_priority_4bit_encoder.sv
// Scoreboard bench for priority_4bit_encoder: high-first, low-first and a twin high-first instance.
module tb_priority_4bit_encoder;

  typedef struct packed {
    logic [1:0] b_hi;
    logic [1:0] b_lo;
    logic       valid;
    logic       multi;
  } exp_t;

  // Hand-computed answers indexed by the request vector.
  localparam logic [1:0] HI_TAB [16] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2,
                                         2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
  localparam logic [1:0] LO_TAB [16] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0,
                                         2'd3, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0};
  localparam logic       MU_TAB [16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
                                         1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] a = 4'd0;
  logic [1:0] b_hi, b_lo, b_eq;
  logic       v_hi, v_lo, v_eq;
  logic       m_hi, m_lo, m_eq;
`ifdef PRIO_ONEHOT_EN
  logic [3:0] g_hi, g_lo, g_eq;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t cur = '0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  priority_4bit_encoder #(.HIGH_FIRST(1'b1)) dut_hi (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b_hi), .valid(v_hi),
`ifdef PRIO_ONEHOT_EN
    .grant(g_hi),
`endif
    .multi(m_hi));

  priority_4bit_encoder #(.HIGH_FIRST(1'b0)) dut_lo (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b_lo), .valid(v_lo),
`ifdef PRIO_ONEHOT_EN
    .grant(g_lo),
`endif
    .multi(m_lo));

  priority_4bit_encoder #(.HIGH_FIRST(1'b1)) dut_eq (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b_eq), .valid(v_eq),
`ifdef PRIO_ONEHOT_EN
    .grant(g_eq),
`endif
    .multi(m_eq));

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  // Drive one cycle of stimulus and queue what the outputs must show after the next edge.
  task automatic drive(input logic r, input logic e, input logic [3:0] v);
    @(negedge clk);
    rst_n = r;
    en    = e;
    a     = v;
    if (!r)     cur = '0;
    else if (e) cur = '{b_hi: HI_TAB[v], b_lo: LO_TAB[v], valid: (v != 4'd0), multi: MU_TAB[v]};
    exp_q.push_back(cur);
  endtask

  // Monitor: one queued expectation is retired just after every capturing edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("b_hi",    {2'b00, b_hi}, {2'b00, e.b_hi});
        chk("b_lo",    {2'b00, b_lo}, {2'b00, e.b_lo});
        chk("valid_hi", {3'b000, v_hi}, {3'b000, e.valid});
        chk("valid_lo", {3'b000, v_lo}, {3'b000, e.valid});
        chk("multi_hi", {3'b000, m_hi}, {3'b000, e.multi});
        chk("multi_lo", {3'b000, m_lo}, {3'b000, e.multi});
        checks++;
        if (b_eq !== b_hi) begin
          errors++;
          $display("FAIL twin_equiv at %0t: twin b %b first b %b", $time, b_eq, b_hi);
        end
`ifdef PRIO_ONEHOT_EN
        chk("grant_hi", g_hi, e.valid ? (4'b0001 << e.b_hi) : 4'b0000);
`endif
      end
    end
  end

  initial begin
    // Reset held for two edges while a full request vector is presented.
    drive(1'b0, 1'b1, 4'b1111);
    drive(1'b0, 1'b1, 4'b1111);

    // Full sweep of the request space, one vector per clock.
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, i[3:0]);

    // Directed points including the low-first cases.
    drive(1'b1, 1'b1, 4'b1100);
    drive(1'b1, 1'b1, 4'b1000);
    drive(1'b1, 1'b1, 4'b0101);
    drive(1'b1, 1'b1, 4'b0011);
    drive(1'b1, 1'b1, 4'b0000);

    // Hold: load 0100, then present 1000 with en low for three clocks, then enable.
    drive(1'b1, 1'b1, 4'b0100);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 4'b1000);
    drive(1'b1, 1'b1, 4'b1000);

    // Reset mid-stream right after b=3, then reload.
    drive(1'b0, 1'b1, 4'b1000);
    drive(1'b1, 1'b0, 4'b0110);
    drive(1'b1, 1'b1, 4'b0110);

    // Random vectors for twin-instance equivalence.
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b1, 4'($urandom_range(0, 15)));
    drive(1'b1, 1'b0, 4'b0000);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/priority_4bit_encoder.md
Name: priority_4bit_encoder

Overview:
- Registered 4-input priority encoder. Converts a 4-bit request vector `a` into the 2-bit index `b` of the winning request bit, plus a valid flag.
- Used wherever one of four request lines must be selected deterministically.
- Output is registered with one clock of latency. Two instances driven by the same `a` must always produce identical `b`.

Parameters:
- HIGH_FIRST, default 1: selects the priority direction. 1 = a[3] highest, a[0] lowest. 0 = a[0] highest, a[3] lowest.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  synchronous reset, active-low, sampled on rising clk
- en  input  1  load enable; when 1, outputs update from `a` at the next edge
- a  input  4  request vector; bit i set = request i active
- b  output  2  encoded index of the winning request (registered)
- valid  output  1  1 = at least one request bit was set in the captured `a` (registered)
- multi  output  1  1 = two or more request bits were set in the captured `a` (registered)

Behaviour:
- Reset: on a rising clk edge with rst_n=0, b=2'b00, valid=0, multi=0. Reset has priority over en.
- After reset is released, an edge with rst_n=1 and en=1 captures `a`:
  - HIGH_FIRST=1: b = index of the highest set bit.
    - a[3]=1 -> 3
    - else a[2]=1 -> 2
    - else a[1]=1 -> 1
    - else a[0]=1 -> 0
  - HIGH_FIRST=0: b = index of the lowest set bit.
  - valid = |a.
  - multi = 1 when popcount(a) >= 2.
- a = 4'b0000: b=2'b00, valid=0, multi=0. An index of 0 is only meaningful when valid=1.
- rst_n=1, en=0: b, valid and multi hold their previous values.
- Latency: exactly 1 clk from sampling `a` to the updated outputs. No combinational path from `a` or en to any output.
- X/Z on `a` is not handled specially. Benches must drive only 0/1.
- Reset asserted mid-stream: outputs go to reset values at that edge. The first en=1 edge after rst_n returns high loads normally.
- Fully deterministic, with no internal state other than the output registers.

Optional Feature:
- Macro: PRIO_ONEHOT_EN.
- Defined:
  - Adds output port `grant` [3:0], registered alongside `b`.
  - `grant` is the one-hot decode of the winning bit (e.g. HIGH_FIRST=1, a=4'b0110 -> grant=4'b0100).
  - `grant` is 4'b0000 when no request is set, and 4'b0000 after reset.
  - `grant` holds when en=0.
- Not defined: port `grant` and its register are absent. All other behaviour is identical.

Test Plan:
- Reset: rst_n=0 for 2 edges with a=4'b1111, en=1 -> b=0, valid=0, multi=0. Repeat with rst_n=0 mid-stream after b=3 -> b=0, valid=0 at that edge.
- Exhaustive, HIGH_FIRST=1, en=1: sweep a=0..15 one per clock and check the next cycle.
  - a=4'b0000 -> b=0, valid=0, multi=0
  - a=4'b0001 -> b=0, valid=1, multi=0
  - a=4'b0110 -> b=2, valid=1, multi=1
  - a=4'b1011 -> b=3, valid=1, multi=1
- HIGH_FIRST=0 instance:
  - a=4'b1100 -> b=2, multi=1
  - a=4'b1000 -> b=3, multi=0
  - a=4'b0101 -> b=0
- Hold: load a=4'b0100 (b=2), then en=0 with a=4'b1000 for 3 clocks -> b stays 2, valid stays 1. Set en=1 -> b=3 next cycle.
- Dual-instance equivalence: two instances with the same parameters share `a`; 10+ random `a` values, one per clock -> `b` identical (!==) every cycle. Stop on mismatch.
- PRIO_ONEHOT_EN defined, HIGH_FIRST=1:
  - a=4'b0011 -> grant=4'b0010
  - a=4'b0000 -> grant=4'b0000
  - after reset -> grant=4'b0000
